// File: rtl/vending_pkg.sv
// Shared types and default constants for the vending machine controller.
package vending_pkg;

   // Sale-cycle states; the encoding is fixed because it is visible on debug taps.
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StCredit   = 2'd1,
      StDispense = 2'd2,
      StChange   = 2'd3
   } vend_state_e;

   localparam int unsigned DefDebounceCycles = 500000;
   localparam int unsigned DefDispenseCycles = 15000000;
   localparam int unsigned DefPrice          = 3;
   localparam int unsigned DefCreditW        = 3;

   // Panel LED pattern for a state: {ocioso, credito, dispensa, troco}.
   function automatic logic [3:0] leds_for(vend_state_e st);
      logic [3:0] l;
      l = 4'b0000;
      case (st)
         StIdle:     l = 4'b1000;
         StCredit:   l = 4'b0100;
         StDispense: l = 4'b0010;
         StChange:   l = 4'b0001;
         default:    l = 4'b1000;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser plus stability counter for one active-low push-button.
// Emits a one-cycle press pulse for each accepted press; releases are filtered
// the same way but produce no pulse.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic botao_n,
   output logic press
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_level;  // accepted level, 1 = released
   logic [CntW-1:0] r_cnt;
   logic            r_press;

   // Synchronise, then count how long the input has disagreed with the accepted level.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= botao_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            // Any bounce back to the accepted level restarts the count.
            r_cnt <= '0;
         end else if (r_cnt == CntMax) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_press <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign press = r_press;

endmodule

// File: rtl/vending_controller.sv
// Vending machine sequencer: debounced buttons drive the sale cycle
// IDLE -> CREDIT -> DISPENSE -> CHANGE with a shared phase timer.
module vending_controller
   import vending_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned DISPENSE_CYCLES = DefDispenseCycles,
   parameter int unsigned PRICE           = DefPrice,
   parameter int unsigned CREDIT_W        = DefCreditW
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                botao_moeda,
   input  logic                botao_compra,
   input  logic                botao_cancela,
   output logic [CREDIT_W-1:0] credito,
   output logic [CREDIT_W-1:0] troco,
   output logic                led_ocioso,
   output logic                led_credito,
   output logic                led_dispensa,
   output logic                led_troco,
   output logic                rejeita
);

   localparam int unsigned TimerW = $clog2(DISPENSE_CYCLES + 1);
   localparam logic [TimerW-1:0]   TimerLoad = TimerW'(DISPENSE_CYCLES - 1);
   localparam logic [CREDIT_W-1:0] MaxCredit = {CREDIT_W{1'b1}};
   localparam logic [CREDIT_W-1:0] PriceVal  = CREDIT_W'(PRICE);

   logic w_coin;
   logic w_buy;
   logic w_cancel;

   vend_state_e         r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] r_troco;
   logic [TimerW-1:0]   r_timer;
   logic [3:0]          r_leds;
   logic                r_rejeita;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_moeda (
      .clock   (clock),
      .reset   (reset),
      .botao_n (botao_moeda),
      .press   (w_coin)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_compra (
      .clock   (clock),
      .reset   (reset),
      .botao_n (botao_compra),
      .press   (w_buy)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cancela (
      .clock   (clock),
      .reset   (reset),
      .botao_n (botao_cancela),
      .press   (w_cancel)
   );

   // Sale-cycle FSM with credit, change, phase timer and registered panel outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= StIdle;
         r_credit  <= '0;
         r_troco   <= '0;
         r_timer   <= '0;
         r_leds    <= leds_for(StIdle);
         r_rejeita <= 1'b0;
      end else begin
         r_rejeita <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_coin) begin
                  r_credit <= CREDIT_W'(1);
                  r_state  <= StCredit;
                  r_leds   <= leds_for(StCredit);
               end
            end
            StCredit: begin
               // Priority cancel > buy > coin; losers are dropped.
               if (w_cancel) begin
                  r_troco  <= r_credit;
                  r_credit <= '0;
                  r_timer  <= TimerLoad;
                  r_state  <= StChange;
                  r_leds   <= leds_for(StChange);
               end else if (w_buy && (r_credit >= PriceVal)) begin
                  r_troco  <= r_credit - PriceVal;
                  r_credit <= '0;
                  r_timer  <= TimerLoad;
                  r_state  <= StDispense;
                  r_leds   <= leds_for(StDispense);
               end else if (w_coin) begin
                  if (r_credit == MaxCredit) begin
                     r_rejeita <= 1'b1;
                  end else begin
                     r_credit <= r_credit + 1'b1;
                  end
               end
            end
            StDispense: begin
               if (w_coin) begin
                  r_rejeita <= 1'b1;
               end
               if (r_timer == '0) begin
                  if (r_troco != '0) begin
                     r_timer <= TimerLoad;
                     r_state <= StChange;
                     r_leds  <= leds_for(StChange);
                  end else begin
                     r_state <= StIdle;
                     r_leds  <= leds_for(StIdle);
                  end
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            StChange: begin
               if (w_coin) begin
                  r_rejeita <= 1'b1;
               end
               if (r_timer == '0) begin
                  r_troco <= '0;
                  r_state <= StIdle;
                  r_leds  <= leds_for(StIdle);
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_leds  <= leds_for(StIdle);
            end
         endcase
      end
   end

   assign credito      = r_credit;
   assign troco        = r_troco;
   assign led_ocioso   = r_leds[3];
   assign led_credito  = r_leds[2];
   assign led_dispensa = r_leds[1];
   assign led_troco    = r_leds[0];
   assign rejeita      = r_rejeita;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller with short debounce and phase times.
module tb_vending_controller;

   logic       clock;
   logic       reset;
   logic       botao_moeda;
   logic       botao_compra;
   logic       botao_cancela;
   logic [2:0] credito;
   logic [2:0] troco;
   logic       led_ocioso;
   logic       led_credito;
   logic       led_dispensa;
   logic       led_troco;
   logic       rejeita;

   int total;
   int bad;

   vending_controller #(
      .DEBOUNCE_CYCLES (4),
      .DISPENSE_CYCLES (10),
      .PRICE           (3),
      .CREDIT_W        (3)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .botao_moeda   (botao_moeda),
      .botao_compra  (botao_compra),
      .botao_cancela (botao_cancela),
      .credito       (credito),
      .troco         (troco),
      .led_ocioso    (led_ocioso),
      .led_credito   (led_credito),
      .led_dispensa  (led_dispensa),
      .led_troco     (led_troco),
      .rejeita       (rejeita)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle just past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Hold the selected buttons low until the controller has reacted (press + 1 edge).
   task automatic press_only(input logic m, input logic b, input logic c);
      @(negedge clock);
      botao_moeda   = ~m;
      botao_compra  = ~b;
      botao_cancela = ~c;
      step(8);
   endtask

   // Release everything and wait until the release is accepted.
   task automatic release_all();
      @(negedge clock);
      botao_moeda   = 1'b1;
      botao_compra  = 1'b1;
      botao_cancela = 1'b1;
      step(7);
   endtask

   task automatic coin();
      press_only(1'b1, 1'b0, 1'b0);
      release_all();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ocioso"}, led_ocioso, 1);
      chk({tag, "_credito_led"}, led_credito, 0);
      chk({tag, "_dispensa"}, led_dispensa, 0);
      chk({tag, "_troco_led"}, led_troco, 0);
      chk({tag, "_credito"}, credito, 0);
      chk({tag, "_troco"}, troco, 0);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      reset         = 1'b1;
      botao_moeda   = 1'b1;
      botao_compra  = 1'b1;
      botao_cancela = 1'b1;
      step(3);
      chk_idle("reset");
      chk("reset_rejeita", rejeita, 0);
      @(negedge clock);
      reset = 1'b0;

      // Bouncy coin: three 2-cycle lows, then a steady low.
      for (int b = 0; b < 3; b++) begin
         @(negedge clock) botao_moeda = 1'b0;
         @(negedge clock);
         @(negedge clock) botao_moeda = 1'b1;
         @(negedge clock);
      end
      chk("bounce_no_press", credito, 0);
      @(negedge clock) botao_moeda = 1'b0;
      step(7);
      chk("bounce_press_edge7", dut.u_deb_moeda.press, 1);
      chk("bounce_credit_pre", credito, 0);
      step(1);
      chk("bounce_credit", credito, 1);
      chk("bounce_led_credito", led_credito, 1);
      chk("bounce_led_ocioso", led_ocioso, 0);
      step(4);
      chk("bounce_single_press", credito, 1);
      release_all();

      // Four coins then buy: DISPENSE 10 cycles, CHANGE 10 cycles with troco 1.
      coin();
      coin();
      coin();
      chk("four_coins", credito, 4);
      press_only(1'b0, 1'b1, 1'b0);
      chk("buy4_dispensa", led_dispensa, 1);
      chk("buy4_troco", troco, 1);
      chk("buy4_credito", credito, 0);
      @(negedge clock) botao_compra = 1'b1;
      for (int i = 1; i < 10; i++) begin
         step(1);
         chk("buy4_disp_hold", led_dispensa, 1);
      end
      step(1);
      chk("buy4_change_led", led_troco, 1);
      chk("buy4_disp_off", led_dispensa, 0);
      chk("buy4_change_troco", troco, 1);
      for (int i = 1; i < 10; i++) begin
         step(1);
         chk("buy4_change_hold", led_troco, 1);
      end
      step(1);
      chk_idle("buy4_end");

      // Exact price: DISPENSE then straight to IDLE; a coin during DISPENSE is refused.
      coin();
      coin();
      coin();
      chk("three_coins", credito, 3);
      press_only(1'b0, 1'b1, 1'b0);
      chk("buy3_dispensa", led_dispensa, 1);
      chk("buy3_troco", troco, 0);
      @(negedge clock);
      botao_compra = 1'b1;
      botao_moeda  = 1'b0;
      for (int i = 1; i < 10; i++) begin
         step(1);
         chk("buy3_disp_hold", led_dispensa, 1);
         chk("buy3_no_change", led_troco, 0);
         chk("buy3_rejeita", rejeita, (i == 8) ? 1 : 0);
      end
      step(1);
      chk_idle("buy3_end");
      release_all();
      chk("buy3_coin_dropped", credito, 0);

      // Insufficient credit: buy ignored, then cancel refunds.
      coin();
      coin();
      chk("two_coins", credito, 2);
      press_only(1'b0, 1'b1, 1'b0);
      chk("buy2_ignored", credito, 2);
      chk("buy2_led_credito", led_credito, 1);
      chk("buy2_no_dispense", led_dispensa, 0);
      release_all();
      press_only(1'b0, 1'b0, 1'b1);
      chk("cancel_led_troco", led_troco, 1);
      chk("cancel_troco", troco, 2);
      chk("cancel_credito", credito, 0);
      @(negedge clock) botao_cancela = 1'b1;
      step(9);
      chk("cancel_change_hold", led_troco, 1);
      step(1);
      chk_idle("cancel_end");

      // Saturation and cancel-over-buy priority.
      for (int k = 1; k <= 8; k++) begin
         press_only(1'b1, 1'b0, 1'b0);
         chk("sat_credito", credito, (k < 8) ? k : 7);
         chk("sat_rejeita", rejeita, (k == 8) ? 1 : 0);
         release_all();
      end
      chk("sat_rejeita_single", rejeita, 0);
      press_only(1'b0, 1'b1, 1'b1);
      chk("prio_led_troco", led_troco, 1);
      chk("prio_no_dispense", led_dispensa, 0);
      chk("prio_troco", troco, 7);
      chk("prio_credito", credito, 0);
      @(negedge clock);
      botao_compra  = 1'b1;
      botao_cancela = 1'b1;
      step(10);
      chk_idle("prio_end");

      // Reset in the middle of DISPENSE with the coin button held through it.
      coin();
      coin();
      coin();
      press_only(1'b0, 1'b1, 1'b0);
      chk("rst_in_dispense", led_dispensa, 1);
      @(negedge clock) botao_compra = 1'b1;
      step(3);
      @(negedge clock);
      reset       = 1'b1;
      botao_moeda = 1'b0;
      step(1);
      chk_idle("rst_mid");
      chk("rst_mid_rejeita", rejeita, 0);
      @(negedge clock) reset = 1'b0;
      step(7);
      chk("rst_held_press", dut.u_deb_moeda.press, 1);
      chk("rst_held_pre", credito, 0);
      step(1);
      chk("rst_held_credito", credito, 1);
      chk("rst_held_led", led_credito, 1);
      release_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
